// File: rtl/tdm_demultiplexer.sv
// Receive side of the time-multiplexed data bus: re-aligns on FrameStart and publishes whole frames.
// Optional per-beat even-parity checking is enabled by defining PARITY_CHECK_EN.
//
// state   | meaning
// HUNT    | waiting for a beat carrying FrameStart (channel 0)
// COLLECT | filling channel slots 1..NUM_CH-1 of the current frame
module tdm_demultiplexer #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_CH     = 4,
  parameter int SLOT_W     = $clog2(NUM_CH)
) (
  input  logic                           Clock,
  input  logic                           nReset,
  input  logic [DATA_WIDTH-1:0]          DataIn,
  input  logic                           DataValid,
  input  logic                           FrameStart,
  input  logic                           ParityIn,
  output logic [NUM_CH*DATA_WIDTH-1:0]   DataOut,
  output logic                           FrameValid,
  output logic                           FrameError,
  output logic                           ParityError,
  output logic [SLOT_W-1:0]              Slot
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);
  localparam logic [SLOT_W-1:0] ONE_SLOT  = SLOT_W'(1);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                               state, state_nxt;
  logic [SLOT_W-1:0]                    slot_q, slot_nxt;
  logic [NUM_CH-2:0][DATA_WIDTH-1:0]    shadow_q, shadow_nxt;
  logic [NUM_CH*DATA_WIDTH-1:0]         data_q, data_nxt;
  logic                                 fv_q, fv_nxt;
  logic                                 fe_q, fe_nxt;

`ifdef PARITY_CHECK_EN
  logic pe_q, pe_nxt;
  logic bad_q, bad_nxt;
  logic beat_bad;

  assign beat_bad = (ParityIn != ^DataIn);
`else
  logic unused_parity;

  assign unused_parity = ParityIn;
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= HUNT;
      slot_q   <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
`ifdef PARITY_CHECK_EN
      pe_q     <= 1'b0;
      bad_q    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      slot_q   <= slot_nxt;
      shadow_q <= shadow_nxt;
      data_q   <= data_nxt;
      fv_q     <= fv_nxt;
      fe_q     <= fe_nxt;
`ifdef PARITY_CHECK_EN
      pe_q     <= pe_nxt;
      bad_q    <= bad_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot_q;
    shadow_nxt = shadow_q;
    data_nxt   = data_q;
    fv_nxt     = 1'b0;
    fe_nxt     = 1'b0;
`ifdef PARITY_CHECK_EN
    pe_nxt     = 1'b0;
    bad_nxt    = bad_q;
`endif

    if (DataValid) begin
      case (state)
        HUNT: begin
          if (FrameStart) begin
            shadow_nxt[0] = DataIn;
            slot_nxt      = ONE_SLOT;
            state_nxt     = COLLECT;
`ifdef PARITY_CHECK_EN
            bad_nxt       = beat_bad;
`endif
          end
        end

        COLLECT: begin
          if (FrameStart) begin
            // Short frame: drop the partial frame and restart on this beat as channel 0.
            fe_nxt        = 1'b1;
            shadow_nxt[0] = DataIn;
            slot_nxt      = ONE_SLOT;
`ifdef PARITY_CHECK_EN
            bad_nxt       = beat_bad;
`endif
          end else if (slot_q == LAST_SLOT) begin
            slot_nxt  = '0;
            state_nxt = HUNT;
`ifdef PARITY_CHECK_EN
            bad_nxt   = 1'b0;
            if (bad_q || beat_bad) begin
              pe_nxt = 1'b1;
            end else begin
              fv_nxt   = 1'b1;
              data_nxt = {DataIn, shadow_q};
            end
`else
            fv_nxt    = 1'b1;
            data_nxt  = {DataIn, shadow_q};
`endif
          end else begin
            for (int i = 0; i < NUM_CH - 1; i++) begin
              if (slot_q == SLOT_W'(i)) shadow_nxt[i] = DataIn;
            end
            slot_nxt = slot_q + ONE_SLOT;
`ifdef PARITY_CHECK_EN
            bad_nxt  = bad_q | beat_bad;
`endif
          end
        end

        default: begin
          state_nxt = HUNT;
          slot_nxt  = '0;
        end
      endcase
    end
  end

  assign DataOut    = data_q;
  assign FrameValid = fv_q;
  assign FrameError = fe_q;
  assign Slot       = slot_q;
`ifdef PARITY_CHECK_EN
  assign ParityError = pe_q;
`else
  assign ParityError = 1'b0;
`endif

endmodule
